// File: rtl/decrypt_unit.sv
// -----------------------------------------------------------------------------
// decrypt_unit
// Sequential decryption engine for 8-bit cipher bytes from the nibble-Feistel
// encryption datapath. One cipher byte is accepted per valid/ready handshake.
// The round function is recomputed from the cipher low nibble (which equals
// the plaintext low nibble) and the key snapshot taken at acceptance. The
// recovered plaintext byte is returned on a valid/ready output handshake.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   key_in      in   [7:0] new key value
//   key_load    in   load key_in into the key register (any state)
//   in_valid    in   enc_in holds a cipher byte
//   in_ready    out  block can accept a byte (IDLE)
//   enc_in      in   [7:0] cipher byte {c_hi, c_lo}
//   out_valid   out  number_out holds a result
//   out_ready   in   consumer accepts the result
//   number_out  out  [7:0] recovered plaintext byte
//   busy        out  high while a block is in flight (CALC or OUT)
//   blk_count   out  [7:0] completed-block count (only with DECRYPT_CNT_EN)
//
// Configuration macro: DECRYPT_CNT_EN adds the completed-block counter and
// the blk_count port. Without it neither exists.
// -----------------------------------------------------------------------------
module decrypt_unit (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] key_in,
   input  logic       key_load,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] enc_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] number_out,
   output logic       busy
`ifdef DECRYPT_CNT_EN
   ,
   output logic [7:0] blk_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t     state_r;
   logic [7:0] key_r;
   logic [7:0] key_snap_r;
   logic [7:0] cipher_r;
   logic [7:0] plain_s;

   // Round function: expand the nibble, mix in the key, fold the halves and
   // add key bit 0; the carry out of the 4-bit sum is dropped.
   function automatic logic [3:0] round_f(input logic [3:0] lo, input logic [7:0] k);
      logic [7:0] e;
      logic [7:0] x;
      e = {lo[3], lo[0], lo[2], lo[1], lo[1], lo[0], lo[3], lo[2]};
      x = e ^ k;
      return x[7:4] + x[3:0] + {3'b000, k[0]};
   endfunction

   // Plaintext from the captured cipher byte; low nibble passes through.
   always_comb begin
      plain_s = {cipher_r[7:4] ^ round_f(cipher_r[3:0], key_snap_r), cipher_r[3:0]};
   end

   // Key register: loadable in every state, reset has priority.
   always_ff @(posedge clock) begin
      if (reset) begin
         key_r <= 8'h00;
      end else if (key_load) begin
         key_r <= key_in;
      end else begin
         key_r <= key_r;
      end
   end

   // Control FSM with registered handshake outputs and result register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         key_snap_r <= 8'h00;
         cipher_r   <= 8'h00;
         number_out <= 8'h00;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  // Snapshot uses the pre-edge key, so a simultaneous
                  // key_load only affects later blocks.
                  cipher_r   <= enc_in;
                  key_snap_r <= key_r;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state_r    <= ST_CALC;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_CALC: begin
               number_out <= plain_s;
               out_valid  <= 1'b1;
               state_r    <= ST_OUT;
            end
            ST_OUT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end else begin
                  state_r   <= ST_OUT;
               end
            end
            default: begin
               // Unreachable encoding: drop any block and return to IDLE.
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DECRYPT_CNT_EN
   // Completed-block counter, steps on each output handshake and wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         blk_count <= 8'h00;
      end else if (out_valid && out_ready) begin
         blk_count <= blk_count + 8'h01;
      end else begin
         blk_count <= blk_count;
      end
   end
`endif

endmodule

// File: doc/decrypt_unit.md
# decrypt_unit

Sequential decryption engine for 8-bit cipher bytes produced by the lab's nibble-Feistel encryption datapath. It holds a loadable 8-bit key and accepts one cipher byte per valid/ready handshake. It recomputes the round function from the plaintext low nibble and key, then returns the recovered plaintext byte on a valid/ready output handshake. It sits between the cipher byte stream and the consumer of plaintext, mirroring the encryption path.

## Interface
- No parameters; all widths fixed at 8 bits (data, key).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- key_in  in  8  new key value.
- key_load  in  1  when high at a clock edge, key_reg <= key_in.
- in_valid  in  1  enc_in holds a cipher byte.
- in_ready  out  1  block can accept a byte.
- enc_in  in  8  cipher byte {c_hi[7:4], c_lo[3:0]}.
- out_valid  out  1  number_out holds a result.
- out_ready  in  1  consumer accepts the result.
- number_out  out  8  recovered plaintext byte.
- busy  out  1  high in CALC or OUT.
- blk_count  out  8  completed-block count; present only with DECRYPT_CNT_EN.

## Operation
- Round function f(lo, k):
  - e = expansion(lo) = {lo[3], lo[0], lo[2], lo[1], lo[1], lo[0], lo[3], lo[2]}.
  - x = e ^ k.
  - s = (x[7:4] + x[3:0] + k[0]) mod 16. The carry-out is discarded.
- Plaintext: number_out = {c_hi ^ f(c_lo, key_snap), c_lo}. The low nibble passes through unchanged.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture enc_in into cipher_reg and key_reg into key_snap, then go to CALC.
  - CALC: in_ready=0. Register the result into number_out, set out_valid=1, go to OUT.
  - OUT: out_valid=1 and number_out held stable. On out_valid&&out_ready, clear out_valid and go to IDLE.
- Key handling:
  - key_load is honored in every state.
  - The block in flight always uses key_snap, captured at acceptance.
  - A key_load in the same cycle as acceptance is not seen by that block. That block uses the old key_reg.
- Outputs are changed only in the states described; no combinational paths from inputs to outputs.
- Reset values: state=IDLE, key_reg=0x00, key_snap=0x00, cipher_reg=0x00, number_out=0x00, out_valid=0, in_ready=1 (IDLE), busy=0, blk_count=0x00.
- Reset asserted mid-operation (CALC or OUT) discards the block. Nothing is emitted after reset.
- Reset has priority over key_load.

## Timing
- Input handshake at edge N → CALC during cycle N..N+1.
- number_out and out_valid are valid after edge N+1 (latency 2 edges).
- Minimum throughput: one block per 3 cycles, with out_ready held high.
- in_ready deasserts on the edge after acceptance. in_ready reasserts on the edge after the output handshake.
- Backpressure: out_valid stays high and number_out stays stable for any number of cycles until out_ready=1.
- in_valid while not in IDLE is ignored. enc_in is not sampled.

## Configuration
- DECRYPT_CNT_EN defined:
  - Adds an 8-bit register blk_count and the blk_count port.
  - blk_count increments on each out_valid&&out_ready handshake.
  - Wraps from 0xFF to 0x00.
  - Cleared by reset.
- DECRYPT_CNT_EN undefined: no counter logic, and no blk_count port.

## Test plan
- Reset, then key_load with key_in=0x00; send enc_in=0x35 with out_ready=1. Expect number_out=0x85 and out_valid=1 two edges after acceptance.
- key=0xFF, enc_in=0xA0 → number_out=0x50. key=0x01, enc_in=0x35 → number_out=0x85.
- Backpressure: out_ready=0 for 5 cycles after result. Expect out_valid and number_out=0x85 held, and in_ready=0 throughout. Then out_ready=1 → IDLE the next edge.
- Key change mid-block: accept 0x35 with key 0x00, and pulse key_load with key_in=0xFF during CALC. Expect 0x85 (old key). The next block, 0xA0, yields 0x50.
- Reset asserted in OUT state → out_valid=0, in_ready=1, number_out=0x00, and key_reg=0x00 the next edge.
- With DECRYPT_CNT_EN defined: run 257 blocks → blk_count=0x01. Reset → 0x00.
